// File: rtl/round_sequencer.sv
// round_sequencer: game-round controller driving the interval timer/display block.
// Each round reloads the timer, shows the mole, then ends on a hit or a timeout.
// It also tracks round/score/misses and shortens the interval as rounds advance.
module round_sequencer #(
  parameter logic [2:0]  INIT_INTERVAL   = 3'd7,
  parameter logic [2:0]  MIN_INTERVAL    = 3'd2,
  parameter int unsigned ROUNDS_PER_STEP = 4,
  parameter int unsigned MAX_ROUNDS      = 16,
  parameter int unsigned MAX_MISSES      = 3,
  parameter int unsigned ROUND_W         = 5,
  parameter int unsigned SCORE_W         = 8,
  parameter logic        COUNT_DIR       = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit,
  input  logic               timeout,
  output logic               timer_rst_n,
  output logic [2:0]         interval,
  output logic               dir,
  output logic               mole_active,
  output logic [ROUND_W-1:0] round,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         misses,
  output logic               game_over
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_HIT  = 3'd3;
  localparam logic [2:0] S_MISS = 3'd4;
  localparam logic [2:0] S_OVER = 3'd5;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS);
  localparam logic [1:0]         MISS_LIMIT = 2'(MAX_MISSES);

  logic [2:0]         state_q, state_d;
  logic [2:0]         interval_q, interval_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         misses_q, misses_d;
  logic               step_due;

  // The round just finished closes a difficulty step when it is a multiple of the step length.
  assign step_due = ((32'(round_q) % ROUNDS_PER_STEP) == 0);

  // Next-state and counter updates for the round sequence.
  always_comb begin
    state_d    = state_q;
    interval_d = interval_q;
    round_d    = round_q;
    score_d    = score_q;
    misses_d   = misses_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          round_d    = '0;
          score_d    = '0;
          misses_d   = '0;
          interval_d = INIT_INTERVAL;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        round_d = round_q + 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A hit in the same cycle as the timeout still counts as a hit.
        if (hit) begin
          state_d = S_HIT;
        end else if (timeout) begin
          state_d = S_MISS;
        end
      end
      S_HIT: begin
        if (score_q != '1) begin
          score_d = score_q + 1'b1;
        end
        if (round_q == LAST_ROUND) begin
          state_d = S_OVER;
        end else begin
          if (step_due && (interval_q > MIN_INTERVAL)) begin
            interval_d = interval_q - 3'd1;
          end
          state_d = S_ARM;
        end
      end
      S_MISS: begin
        misses_d = misses_q + 2'd1;
        if ((misses_d == MISS_LIMIT) || (round_q == LAST_ROUND)) begin
          state_d = S_OVER;
        end else begin
          if (step_due && (interval_q > MIN_INTERVAL)) begin
            interval_d = interval_q - 3'd1;
          end
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      interval_q <= INIT_INTERVAL;
      round_q    <= '0;
      score_q    <= '0;
      misses_q   <= '0;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      round_q    <= round_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
    end
  end

  assign timer_rst_n = (state_q == S_RUN);
  assign mole_active = (state_q == S_RUN);
  assign game_over   = (state_q == S_OVER);
  assign dir         = COUNT_DIR;
  assign interval    = interval_q;
  assign round       = round_q;
  assign score       = score_q;
  assign misses      = misses_q;

endmodule
